// File: rtl/decoder7_segment.sv
// -----------------------------------------------------------------------------
// decoder7_segment
//
// Registered BCD/hex to seven-segment decoder for one digit of the clock
// display. Each digit position has its own instance.
//
// Parameters:
//   ACTIVE_LOW      1: a segment is lit when its bit is 0 (common-anode board)
//                   0: a segment is lit when its bit is 1
//
// Ports:
//   clk             system clock, rising-edge active
//   rst             asynchronous, active-high reset (output forced "all off")
//   In[3:0]         digit value to display, 0-15
//   blank           1 = all segments off
//   lamp_test       1 = all segments on (overrides blank)
//   segmentDisplay  registered segment drive, bit 0 = a ... bit 6 = g
//
// Build option:
//   DECODER7_HEX_EN defined   -> In 10-15 shows A, b, C, d, E, F
//   DECODER7_HEX_EN undefined -> In 10-15 shows "all off"
// -----------------------------------------------------------------------------
module decoder7_segment #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] In,
    input  logic       blank,
    input  logic       lamp_test,
    output logic [6:0] segmentDisplay
);

    // Driven values for the two override states, already in board polarity.
    localparam logic [6:0] ALL_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [6:0] digitPattern;  // lit segments for In, active-high sense
    logic [6:0] litPattern;    // lit segments after the overrides
    logic [6:0] nextDisplay;   // litPattern converted to board polarity

    // Glyph lookup, segment order g..a.
    always_comb begin
        // NOTE: default assigned first so every path drives digitPattern and
        // no latch is inferred; it also makes unsupported codes show blank.
        digitPattern = 7'h00;
        unique case (In)
            4'd0:  digitPattern = 7'h3F;
            4'd1:  digitPattern = 7'h06;
            4'd2:  digitPattern = 7'h5B;
            4'd3:  digitPattern = 7'h4F;
            4'd4:  digitPattern = 7'h66;
            4'd5:  digitPattern = 7'h6D;
            4'd6:  digitPattern = 7'h7D;
            4'd7:  digitPattern = 7'h07;
            4'd8:  digitPattern = 7'h7F;
            4'd9:  digitPattern = 7'h6F;
`ifdef DECODER7_HEX_EN
            4'd10: digitPattern = 7'h77;  // A
            4'd11: digitPattern = 7'h7C;  // b
            4'd12: digitPattern = 7'h39;  // C
            4'd13: digitPattern = 7'h5E;  // d
            4'd14: digitPattern = 7'h79;  // E
            4'd15: digitPattern = 7'h71;  // F
`else
            4'd10, 4'd11, 4'd12,
            4'd13, 4'd14, 4'd15: digitPattern = 7'h00;
`endif
        endcase
    end

    // Override priority: lamp_test beats blank beats the decoded digit.
    always_comb begin
        litPattern = digitPattern;
        if (lamp_test) begin
            litPattern = 7'h7F;
        end else if (blank) begin
            litPattern = 7'h00;
        end
        nextDisplay = ACTIVE_LOW ? ~litPattern : litPattern;
    end

    // Output register; reset takes effect without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignment for register state so every flop
        // samples its inputs from before the edge.
        if (rst) begin
            segmentDisplay <= ALL_OFF;
        end else begin
            segmentDisplay <= nextDisplay;
        end
    end

endmodule

// File: tb/tb_decoder7_segment.sv
// -----------------------------------------------------------------------------
// tb_decoder7_segment
//
// Directed bench for decoder7_segment. Two instances share the stimulus:
// segLow uses ACTIVE_LOW=1, segHigh uses ACTIVE_LOW=0. Expected values are
// hand-computed constants; outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_decoder7_segment;

    logic       clk;
    logic       rst;
    logic [3:0] In;
    logic       blank;
    logic       lamp_test;
    logic [6:0] segLow;
    logic [6:0] segHigh;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    decoder7_segment #(.ACTIVE_LOW(1'b1)) dutLow (
        .clk            (clk),
        .rst            (rst),
        .In             (In),
        .blank          (blank),
        .lamp_test      (lamp_test),
        .segmentDisplay (segLow)
    );

    decoder7_segment #(.ACTIVE_LOW(1'b0)) dutHigh (
        .clk            (clk),
        .rst            (rst),
        .In             (In),
        .blank          (blank),
        .lamp_test      (lamp_test),
        .segmentDisplay (segHigh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] observed,
                         input logic [6:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and land 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed expectations (ACTIVE_LOW=1 / ACTIVE_LOW=0).
    logic [6:0] digitLow  [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [6:0] digitHigh [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                   7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
`ifdef DECODER7_HEX_EN
    logic [6:0] hexLow  [6] = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [6:0] hexHigh [6] = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`else
    logic [6:0] hexLow  [6] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    logic [6:0] hexHigh [6] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
`endif

    initial begin
        rst       = 1'b1;
        In        = 4'd0;
        blank     = 1'b0;
        lamp_test = 1'b0;

        // Reset applied before any clock edge: output already "all off".
        #2;
        check("reset_async_low",  segLow,  7'h7F);
        check("reset_async_high", segHigh, 7'h00);

        // Still "all off" across an edge while rst is held.
        step();
        check("reset_held_low", segLow, 7'h7F);

        // Release with In=0: decode appears after the next edge.
        rst = 1'b0;
        step();
        check("reset_release_low",  segLow,  7'h40);
        check("reset_release_high", segHigh, 7'h3F);

        // Digit sweep, a new value every cycle.
        for (int i = 0; i < 10; i++) begin
            In = 4'(i);
            step();
            check($sformatf("digit%0d_low", i),  segLow,  digitLow[i]);
            check($sformatf("digit%0d_high", i), segHigh, digitHigh[i]);
        end

        // Letters 10..15 (contents depend on the hex build option).
        for (int i = 0; i < 6; i++) begin
            In = 4'(i + 10);
            step();
            check($sformatf("hex%0d_low", i + 10),  segLow,  hexLow[i]);
            check($sformatf("hex%0d_high", i + 10), segHigh, hexHigh[i]);
        end

        // Overrides with In=5.
        In = 4'd5;
        step();
        check("in5_low", segLow, 7'h12);

        blank = 1'b1;
        #1;
        check("blank_before_edge_low", segLow, 7'h12);  // one-cycle latency
        step();
        check("blank_low",  segLow,  7'h7F);
        check("blank_high", segHigh, 7'h00);

        blank     = 1'b0;
        lamp_test = 1'b1;
        step();
        check("lamp_low",  segLow,  7'h00);
        check("lamp_high", segHigh, 7'h7F);

        blank = 1'b1;
        step();
        check("blank_and_lamp_low",  segLow,  7'h00);
        check("blank_and_lamp_high", segHigh, 7'h7F);

        blank     = 1'b0;
        lamp_test = 1'b0;
        step();
        check("override_release_low",  segLow,  7'h12);
        check("override_release_high", segHigh, 7'h6D);

        // Seconds-low rollover 9 -> 0 on consecutive cycles.
        In = 4'd9;
        step();
        check("rollover9_low", segLow, 7'h10);
        In = 4'd0;
        step();
        check("rollover0_low", segLow, 7'h40);

        // Mid-operation reset between edges.
        In = 4'd8;
        step();
        check("pre_reset_low",  segLow,  7'h00);
        check("pre_reset_high", segHigh, 7'h7F);
        #2;
        rst = 1'b1;
        #1;
        check("reset_mid_low",  segLow,  7'h7F);
        check("reset_mid_high", segHigh, 7'h00);
        step();
        check("reset_mid_held_high", segHigh, 7'h00);

        In = 4'd1;
        #2;
        rst = 1'b0;
        step();
        check("after_reset_low",  segLow,  7'h79);
        check("after_reset_high", segHigh, 7'h06);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
